// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Shared types, counter widths and default parameter values
//                for the game round engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    // Round engine states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        END  = 2'd2
    } round_state_t;

    // Display counter widths
    localparam int SCORE_W = 8;
    localparam int LIVES_W = 4;
    localparam int TIME_W  = 8;

    // Default parameter values
    localparam int DEF_CLK_HZ        = 50_000_000;
    localparam int DEF_ROUND_SECONDS = 60;
    localparam int DEF_WIN_SCORE     = 20;
    localparam int DEF_LIVES         = 3;

endpackage
`default_nettype wire

// File: rtl/tick_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tick_divider
//  Description : Free-running 0..CLK_HZ-1 counter that advances only while
//                enabled and emits a one-cycle tick on the wrap cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_divider
    import game_pkg::*;
#(
    parameter int CLK_HZ = DEF_CLK_HZ
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    // A one-cycle period still needs a 1-bit counter to stay legal
    localparam int               CNT_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] r_cnt;

    // Strobe during the last count so the consumer updates on the wrap edge
    assign tick = en && (r_cnt == C_LAST);

    // Divider count: clear wins, otherwise advance only while enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= tick ? '0 : r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/game_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : game_round_ctrl
//  Description : Round engine: countdown timer, score and lives counters,
//                held game-over/win result and ready indication.
//  Revision    : 1.0 - initial release
// ============================================================================
module game_round_ctrl
    import game_pkg::*;
#(
    parameter int CLK_HZ        = DEF_CLK_HZ,
    parameter int ROUND_SECONDS = DEF_ROUND_SECONDS,
    parameter int WIN_SCORE     = DEF_WIN_SCORE,
    parameter int LIVES         = DEF_LIVES
) (
    input  logic               CLOCK_50,
    input  logic               reset_n,
    input  logic               startGameNow,
    input  logic               gamePlaying,
    input  logic               resetMaster,
    input  logic               hit,
    input  logic               miss,
    output logic               ready,
    output logic               GameOver,
    output logic               GameWonOut,
    output logic [SCORE_W-1:0] score,
    output logic [LIVES_W-1:0] lives_left,
    output logic [TIME_W-1:0]  time_left
);

    localparam logic [SCORE_W-1:0] C_WIN   = SCORE_W'(WIN_SCORE);
    localparam logic [LIVES_W-1:0] C_LIVES = LIVES_W'(LIVES);
    localparam logic [TIME_W-1:0]  C_TIME  = TIME_W'(ROUND_SECONDS);

    round_state_t       r_state;
    logic               r_ready;
    logic               r_game_over;
    logic               r_game_won;
    logic [SCORE_W-1:0] r_score;
    logic [LIVES_W-1:0] r_lives;
    logic [TIME_W-1:0]  r_time;
    logic               r_playing_q;

    logic               w_start;
    logic               w_tick;
    logic               w_hit;
    logic               w_miss;
    logic               w_abort;
    logic [SCORE_W-1:0] w_score_nx;
    logic [LIVES_W-1:0] w_lives_nx;
    logic [TIME_W-1:0]  w_time_nx;
    logic               w_win;
    logic               w_lose;

    // A start is only honoured from IDLE; it also restarts the second divider
    assign w_start = (r_state == IDLE) && startGameNow;

    tick_divider #(
        .CLK_HZ (CLK_HZ)
    ) u_tick_divider (
        .clk   (CLOCK_50),
        .rst_n (reset_n),
        .en    (r_state == PLAY),
        .clr   (w_start),
        .tick  (w_tick)
    );

    // Player events count only while the session says the round is live
    assign w_hit  = gamePlaying && hit;
    assign w_miss = gamePlaying && miss;

    // Abort on the falling edge of gamePlaying, so a round whose session
    // level rises after the start strobe is not torn down immediately
    assign w_abort = r_playing_q && !gamePlaying;

    // Post-update counter values; the end-of-round decision looks at these
    assign w_score_nx = (w_hit  && (r_score != '1)) ? r_score + 1'b1 : r_score;
    assign w_lives_nx = (w_miss && (r_lives != '0)) ? r_lives - 1'b1 : r_lives;
    assign w_time_nx  = (w_tick && (r_time  != '0)) ? r_time  - 1'b1 : r_time;

    assign w_win  = (w_score_nx >= C_WIN);
    assign w_lose = (w_lives_nx == '0) || (w_time_nx == '0);

    // Round state machine with registered status outputs and counters
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_ready     <= 1'b1;
            r_game_over <= 1'b0;
            r_game_won  <= 1'b0;
            r_score     <= '0;
            r_lives     <= '0;
            r_time      <= '0;
            r_playing_q <= 1'b0;
        end else begin
            r_playing_q <= gamePlaying;
            case (r_state)
                IDLE: begin
                    if (startGameNow) begin
                        r_state <= PLAY;
                        r_ready <= 1'b0;
                        r_score <= '0;
                        r_lives <= C_LIVES;
                        r_time  <= C_TIME;
                    end
                end
                PLAY: begin
                    if (w_abort) begin
                        // Counters freeze as they are, no result is reported
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                    end else begin
                        r_score <= w_score_nx;
                        r_lives <= w_lives_nx;
                        r_time  <= w_time_nx;
                        if (w_win) begin
                            r_state     <= END;
                            r_game_over <= 1'b1;
                            r_game_won  <= 1'b1;
                        end else if (w_lose) begin
                            r_state     <= END;
                            r_game_over <= 1'b1;
                            r_game_won  <= 1'b0;
                        end
                    end
                end
                END: begin
                    // Result and counters hold until the session acknowledges
                    if (resetMaster) begin
                        r_state     <= IDLE;
                        r_ready     <= 1'b1;
                        r_game_over <= 1'b0;
                        r_game_won  <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_ready     <= 1'b1;
                    r_game_over <= 1'b0;
                    r_game_won  <= 1'b0;
                end
            endcase
        end
    end

    assign ready      = r_ready;
    assign GameOver   = r_game_over;
    assign GameWonOut = r_game_won;
    assign score      = r_score;
    assign lives_left = r_lives;
    assign time_left  = r_time;

endmodule
`default_nettype wire

// File: doc/game_round_ctrl.md
# game_round_ctrl

Round engine on the other side of the session handshake. It accepts the one-cycle start strobe and the in-game level from the session controller, then runs one round: a per-second countdown, a score counter and a lives counter. It reports the round result back as a held game-over level with a win flag, and raises `ready` whenever a new round may be started.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000: clock cycles per one-second tick.
- `ROUND_SECONDS`, 60: round length in seconds, range 1..255.
- `WIN_SCORE`, 20: score that wins the round, range 1..255.
- `LIVES`, 3: lives at round start, range 1..15.

Ports:
- `CLOCK_50`, in, 1: sole clock; every flop is rising-edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `startGameNow`, in, 1: one-cycle start strobe from the session controller.
- `gamePlaying`, in, 1: level, high while the session considers the round live.
- `resetMaster`, in, 1: one-cycle acknowledge of the game-over condition.
- `hit`, in, 1: one-cycle pulse, player scored a point.
- `miss`, in, 1: one-cycle pulse, player lost a life.
- `ready`, out, 1: high only in IDLE.
- `GameOver`, out, 1: high throughout END.
- `GameWonOut`, out, 1: round result, valid whenever `GameOver` is high.
- `score`, out, 8: current score.
- `lives_left`, out, 4: current lives.
- `time_left`, out, 8: seconds remaining.

## Operation
- Three states: IDLE, PLAY, END.
- IDLE:
  - `ready`=1.
  - On `startGameNow`=1, load `score`=0, `lives_left`=LIVES, `time_left`=ROUND_SECONDS, clear the tick divider, and go to PLAY.
  - All other inputs are ignored.
- PLAY:
  - `hit` and `miss` are counted only when `gamePlaying`=1.
  - A `hit` increments `score`, saturating at 255.
  - A `miss` decrements `lives_left`, saturating at 0.
  - Each one-second tick decrements `time_left`, saturating at 0.
  - End-of-round is evaluated on the post-update values of the same cycle.
    - Win: `score` ≥ WIN_SCORE. Go to END with `GameWonOut`=1.
    - Lose: otherwise, if `lives_left`=0 or `time_left`=0. Go to END with `GameWonOut`=0.
  - Priority: a win beats a simultaneous loss. If `hit` and `miss` arrive together, both counters update.
  - `startGameNow` is ignored in PLAY.
- END:
  - `GameOver`=1.
  - `GameWonOut`, `score`, `lives_left` and `time_left` are frozen.
  - `hit`, `miss`, ticks and `startGameNow` are ignored.
  - `resetMaster`=1 moves to IDLE. The counters keep their frozen values for display until the next start. `GameWonOut` clears on entry to IDLE.
- Abort: if `gamePlaying` falls while in PLAY, go to IDLE directly. `GameOver` does not assert and counters freeze.
- Reset (any time, including mid-round): state IDLE, `ready`=1, `GameOver`=0, `GameWonOut`=0, `score`=0, `lives_left`=0, `time_left`=0, tick divider=0.

## Timing
- All outputs are registered.
- `ready` falls on the first clock edge after a `startGameNow` pulse sampled in IDLE.
- A terminating event sampled at edge N gives `GameOver`=1 and valid `GameWonOut` after edge N. Both stay stable until `resetMaster` is sampled. The session controller samples `GameWonOut` the cycle after `GameOver` rises; it is already valid then.
- `resetMaster` sampled at edge M: `GameOver`=0 and `ready`=1 after edge M.
- Tick divider:
  - Counts 0..CLK_HZ-1 only in PLAY and strobes on wrap.
  - The first decrement of `time_left` occurs CLK_HZ cycles after PLAY entry.
  - The divider holds its value in IDLE and END.
  - Width is $clog2(CLK_HZ).
- Minimum start-to-start interval: 3 cycles (PLAY, END, IDLE).

## Structure
- Shared package `game_pkg`:
  - `round_state_t` enum, 2 bits: IDLE=0, PLAY=1, END=2.
  - Width constants `SCORE_W`=8, `LIVES_W`=4, `TIME_W`=8.
  - The default value of each parameter.
- One sub-module, `tick_divider`: parameter CLK_HZ, inputs `en` and `clr`, output `tick` (one-cycle strobe).

## Test plan
All scenarios use CLK_HZ=10, ROUND_SECONDS=3, WIN_SCORE=4, LIVES=2.
- **Win:** start, then 4 `hit` pulses with `gamePlaying`=1 → `GameOver`=1 and `GameWonOut`=1 one cycle after the 4th hit; `score`=4. `resetMaster` → `ready`=1 next cycle.
- **Timeout:** start, no activity → `time_left` steps 3→2→1→0 at 10-cycle intervals; `GameOver`=1, `GameWonOut`=0 on the cycle `time_left` reaches 0, i.e. 30 cycles after start.
- **Lives:** start, 2 `miss` pulses → `lives_left`=0, `GameOver`=1, `GameWonOut`=0. A 3rd `miss` in END leaves `lives_left`=0.
- **Simultaneous:** `score`=3, `lives_left`=1, then `hit` and `miss` in the same cycle → `score`=4, `lives_left`=0, `GameWonOut`=1.
- **Ignored inputs:**
  - `hit` while `gamePlaying`=0 in PLAY: `score` unchanged.
  - `startGameNow` in PLAY: no restart, `time_left` unchanged.
  - `startGameNow` in END: `ready` stays 0.
- **Reset/abort:**
  - `reset_n` low mid-PLAY with `score`=2 → all outputs at reset values immediately, without waiting for a clock edge.
  - `gamePlaying` dropped in PLAY → IDLE next cycle, `GameOver` never asserted.
